// File: rtl/pipe_pkg.sv
// Shared pipeline constants for the hazard scoreboard and its per-register entries.
package pipe_pkg;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned LAT_W    = 3;
  localparam int unsigned STALL_CW = 16;

  localparam logic [LAT_W-1:0] LAT_INF  = '1;
  localparam logic [LAT_W-1:0] LAT_ALU  = '0;
  localparam logic [LAT_W-1:0] LAT_LOAD = 3'd1;
  localparam logic [LAT_W-1:0] LAT_DIV  = LAT_INF;

  typedef enum logic [1:0] {
    ENT_HOLD,
    ENT_SET,
    ENT_CLR,
    ENT_DEC
  } ent_op_e;
endpackage

// File: rtl/hazard_scoreboard_sb_entry.sv
// One scoreboard countdown: set on issue, clear on writeback, otherwise count down
// unless parked at the unbounded value.
module sb_entry
  import pipe_pkg::*;
#(
  parameter int unsigned LAT_W = pipe_pkg::LAT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             set_i,
  input  logic [LAT_W-1:0] set_val_i,
  input  logic             clr_i,
  output logic [LAT_W-1:0] cnt_o,
  output logic             busy_o,
  output logic             inf_o
);

  logic [LAT_W-1:0] cnt_q;
  ent_op_e          op;

  assign cnt_o  = cnt_q;
  assign busy_o = (cnt_q != '0);
  assign inf_o  = (cnt_q == '1);

  always_comb begin
    op = ENT_HOLD;
    if (set_i)                op = ENT_SET;
    else if (clr_i)           op = ENT_CLR;
    else if (busy_o && !inf_o) op = ENT_DEC;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      case (op)
        ENT_SET: cnt_q <= set_val_i;
        ENT_CLR: cnt_q <= '0;
        ENT_DEC: cnt_q <= cnt_q - LAT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register scoreboard hazard unit beside ID: RAW/WAW stall generation over
// in-flight writes of arbitrary latency, plus a saturating stall-cycle counter.
module hazard_scoreboard
  import pipe_pkg::*;
#(
  parameter int unsigned REG_AW   = pipe_pkg::REG_AW,
  parameter int unsigned LAT_W    = pipe_pkg::LAT_W,
  parameter int unsigned STALL_CW = pipe_pkg::STALL_CW
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  id_valid_i,
  input  logic [REG_AW-1:0]     id_rs1_i,
  input  logic [REG_AW-1:0]     id_rs2_i,
  input  logic                  id_use_rs1_i,
  input  logic                  id_use_rs2_i,
  input  logic [REG_AW-1:0]     id_rd_i,
  input  logic                  id_wen_i,
  input  logic [LAT_W-1:0]      id_lat_i,
  input  logic                  flush_i,
  input  logic                  wb_done_i,
  input  logic [REG_AW-1:0]     wb_rd_i,
  output logic                  pc_stall_o,
  output logic                  ifid_stall_o,
  output logic                  ctrl_mux_o,
  output logic [2**REG_AW-1:0]  busy_o,
  output logic [STALL_CW-1:0]   stall_cnt_o
);

  localparam int unsigned NUM_REGS = 2**REG_AW;

  logic [NUM_REGS-1:0][LAT_W-1:0] cnt;
  logic [NUM_REGS-1:0]            busy;
  logic [NUM_REGS-1:0]            inf;
  logic                           raw, waw, stall, issue;

  // x0 is never tracked; its slot reads as permanently idle.
  assign cnt[0]  = '0;
  assign busy[0] = 1'b0;
  assign inf[0]  = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
    sb_entry #(.LAT_W(LAT_W)) u_entry (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .set_i     (issue && (id_rd_i == REG_AW'(r))),
      .set_val_i (id_lat_i),
      .clr_i     (wb_done_i && (wb_rd_i == REG_AW'(r))),
      .cnt_o     (cnt[r]),
      .busy_o    (busy[r]),
      .inf_o     (inf[r])
    );
  end

  always_comb begin
    raw = (id_use_rs1_i && (id_rs1_i != '0) && busy[id_rs1_i]) ||
          (id_use_rs2_i && (id_rs2_i != '0) && busy[id_rs2_i]);
    // A younger write may only land once the older one to the same rd is no later.
    waw = id_wen_i && (id_rd_i != '0) && busy[id_rd_i] &&
          (inf[id_rd_i] || (cnt[id_rd_i] > id_lat_i));
    stall = id_valid_i && !flush_i && (raw || waw);
    issue = id_valid_i && !flush_i && !stall && id_wen_i && (id_rd_i != '0);
  end

  assign pc_stall_o   = stall;
  assign ifid_stall_o = stall;
  assign ctrl_mux_o   = stall;
  assign busy_o       = busy;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_o <= '0;
    end else if (stall && (stall_cnt_o != '1)) begin
      stall_cnt_o <= stall_cnt_o + STALL_CW'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: vector table, directed corner sequences,
// and random stimulus against a cycles-remaining reference model.
module tb_hazard_scoreboard;
  import pipe_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        id_valid_i, id_use_rs1_i, id_use_rs2_i, id_wen_i, flush_i, wb_done_i;
  logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i, wb_rd_i;
  logic [2:0]  id_lat_i;
  logic        pc_stall_o, ifid_stall_o, ctrl_mux_o;
  logic [31:0] busy_o;
  logic [15:0] stall_cnt_o;

  always #5 clk_i = ~clk_i;

  hazard_scoreboard #(.REG_AW(5), .LAT_W(3), .STALL_CW(16)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .id_valid_i   (id_valid_i),
    .id_rs1_i     (id_rs1_i),
    .id_rs2_i     (id_rs2_i),
    .id_use_rs1_i (id_use_rs1_i),
    .id_use_rs2_i (id_use_rs2_i),
    .id_rd_i      (id_rd_i),
    .id_wen_i     (id_wen_i),
    .id_lat_i     (id_lat_i),
    .flush_i      (flush_i),
    .wb_done_i    (wb_done_i),
    .wb_rd_i      (wb_rd_i),
    .pc_stall_o   (pc_stall_o),
    .ifid_stall_o (ifid_stall_o),
    .ctrl_mux_o   (ctrl_mux_o),
    .busy_o       (busy_o),
    .stall_cnt_o  (stall_cnt_o)
  );

  // Reference: cycles remaining per register, -1 meaning "until writeback".
  int          m_cnt [32];
  int unsigned m_stall;
  int          n_tests = 0;
  int          n_fail  = 0;

  typedef struct {
    logic       valid;
    logic [4:0] rs1;
    logic       use1;
    logic [4:0] rs2;
    logic       use2;
    logic [4:0] rd;
    logic       wen;
    logic [2:0] lat;
    logic       flush;
    logic       wb;
    logic [4:0] wb_rd;
    logic       exp_stall;
    logic [31:0] exp_busy;
  } vec_t;

  vec_t tbl [13];

  function automatic logic exp_stall();
    bit raw, waw;
    int c;
    raw = (id_use_rs1_i && id_rs1_i != 0 && m_cnt[id_rs1_i] != 0) ||
          (id_use_rs2_i && id_rs2_i != 0 && m_cnt[id_rs2_i] != 0);
    c   = m_cnt[id_rd_i];
    waw = id_wen_i && id_rd_i != 0 && c != 0 && (c < 0 || c > int'(id_lat_i));
    return id_valid_i && !flush_i && (raw || waw);
  endfunction

  function automatic logic [31:0] exp_busy();
    logic [31:0] b = '0;
    for (int r = 1; r < 32; r++) if (m_cnt[r] != 0) b[r] = 1'b1;
    return b;
  endfunction

  task automatic model_clock(input logic st);
    logic iss;
    iss = id_valid_i && !flush_i && !st && id_wen_i && id_rd_i != 0;
    for (int r = 1; r < 32; r++) begin
      if (iss && r == int'(id_rd_i))          m_cnt[r] = (id_lat_i == 3'd7) ? -1 : int'(id_lat_i);
      else if (wb_done_i && r == int'(wb_rd_i)) m_cnt[r] = 0;
      else if (m_cnt[r] > 0)                  m_cnt[r] = m_cnt[r] - 1;
    end
    if (st && m_stall < 65535) m_stall++;
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    m_stall = 0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    id_valid_i = 0; id_rs1_i = 0; id_rs2_i = 0; id_use_rs1_i = 0; id_use_rs2_i = 0;
    id_rd_i = 0; id_wen_i = 0; id_lat_i = 0; flush_i = 0; wb_done_i = 0; wb_rd_i = 0;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd, input logic wen, input logic [2:0] lat);
    id_valid_i = v; id_rs1_i = rs1; id_use_rs1_i = u1; id_rs2_i = rs2; id_use_rs2_i = u2;
    id_rd_i = rd; id_wen_i = wen; id_lat_i = lat;
  endtask

  // Called at posedge+1 with inputs applied; samples at negedge, returns at next posedge+1.
  task automatic step(input bit chk, output logic st, output logic [31:0] bz);
    logic est;
    @(negedge clk_i);
    est = exp_stall();
    if (chk) begin
      check("stall_outs", {29'd0, pc_stall_o, ifid_stall_o, ctrl_mux_o}, {29'd0, {3{est}}});
      check("busy", busy_o, exp_busy());
      check("stall_cnt", {16'd0, stall_cnt_o}, m_stall);
    end
    st = pc_stall_o;
    bz = busy_o;
    @(posedge clk_i);
    model_clock(est);
    #1;
  endtask

  logic        st;
  logic [31:0] bz;
  int          nst;

  initial begin
    //             v  rs1  u1 rs2 u2 rd  wen lat fl wb wbrd  st busy
    tbl[0]  = '{1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 32'h0};
    tbl[1]  = '{1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h20};
    tbl[2]  = '{1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0, 0, 32'h0};
    tbl[3]  = '{1, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 32'h0};
    tbl[4]  = '{1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0};
    tbl[5]  = '{1, 0, 0, 0, 0, 9, 1, 3, 0, 1, 9, 0, 32'h0};
    tbl[6]  = '{1, 9, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h200};
    tbl[7]  = '{1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 1, 32'h200};
    tbl[8]  = '{1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 1, 32'h200};
    tbl[9]  = '{1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0, 32'h0};
    tbl[10] = '{1, 0, 0, 0, 0, 9, 1, 3, 0, 0, 0, 0, 32'h0};
    tbl[11] = '{1, 0, 0, 0, 0, 9, 1, 5, 0, 0, 0, 0, 32'h200};
    tbl[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h200};

    idle();
    model_reset();
    rst_i = 1'b0;
    #12;
    check("reset_busy", busy_o, 32'h0);
    check("reset_stall", {29'd0, pc_stall_o, ifid_stall_o, ctrl_mux_o}, 32'h0);
    check("reset_stall_cnt", {16'd0, stall_cnt_o}, 32'h0);
    @(posedge clk_i); #1;
    rst_i = 1'b1;

    // Vector table: load-use, x0 handling, same-cycle issue+wb, flush, WAW ordering.
    for (int i = 0; i < 13; i++) begin
      set_id(tbl[i].valid, tbl[i].rs1, tbl[i].use1, tbl[i].rs2, tbl[i].use2,
             tbl[i].rd, tbl[i].wen, tbl[i].lat);
      flush_i = tbl[i].flush; wb_done_i = tbl[i].wb; wb_rd_i = tbl[i].wb_rd;
      step(1, st, bz);
      check($sformatf("tbl%0d_stall", i), {31'd0, st}, {31'd0, tbl[i].exp_stall});
      check($sformatf("tbl%0d_busy", i), bz, tbl[i].exp_busy);
    end
    idle();
    check("load_use_stall_cnt", {16'd0, stall_cnt_o}, 32'd3);

    // Divide to x7, consumer on rs2 held until writeback on the 20th stalled cycle.
    set_id(1, 0, 0, 0, 0, 7, 1, 3'd7);
    step(1, st, bz);
    set_id(1, 0, 0, 7, 1, 0, 0, 0);
    nst = 0;
    for (int k = 0; k < 20; k++) begin
      if (k == 19) begin wb_done_i = 1; wb_rd_i = 7; end
      step(1, st, bz);
      if (st) nst++;
    end
    wb_done_i = 0; wb_rd_i = 0;
    check("div_stall_len", nst, 32'd20);
    step(1, st, bz);
    check("div_release", {31'd0, st}, 32'd0);

    // WAW against pending divide; independent ALU write proceeds.
    set_id(1, 0, 0, 0, 0, 7, 1, 3'd7);
    step(1, st, bz);
    set_id(1, 0, 0, 0, 0, 7, 1, 3'd0);
    step(1, st, bz);
    check("waw_div_alu", {31'd0, st}, 32'd1);
    set_id(1, 0, 0, 0, 0, 8, 1, 3'd0);
    step(1, st, bz);
    check("alu_other_rd", {31'd0, st}, 32'd0);
    set_id(1, 0, 0, 0, 0, 7, 1, 3'd0);
    wb_done_i = 1; wb_rd_i = 7;
    step(1, st, bz);
    check("waw_wb_cycle", {31'd0, st}, 32'd1);
    wb_done_i = 0; wb_rd_i = 0;
    step(1, st, bz);
    check("waw_after_wb", {31'd0, st}, 32'd0);

    // Random traffic over a small register window so hazards are frequent.
    for (int k = 0; k < 3000; k++) begin
      int unsigned sel;
      sel = $urandom_range(0, 5);
      set_id($urandom_range(0, 9) != 0, 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             (sel == 5) ? 3'd7 : 3'(sel));
      flush_i   = ($urandom_range(0, 9) == 0);
      wb_done_i = ($urandom_range(0, 3) == 0);
      wb_rd_i   = 5'($urandom_range(0, 7));
      step(1, st, bz);
    end

    // Saturate the stall counter behind a divide, then reset mid-divide.
    idle();
    wb_done_i = 1; wb_rd_i = 7;
    step(1, st, bz);
    idle();
    set_id(1, 0, 0, 0, 0, 7, 1, 3'd7);
    step(1, st, bz);
    set_id(1, 7, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 65540; k++) step(0, st, bz);
    step(1, st, bz);
    check("sat_stall_cnt", {16'd0, stall_cnt_o}, 32'h0000FFFF);
    check("pre_reset_busy7", {31'd0, busy_o[7]}, 32'd1);
    #2;
    rst_i = 1'b0;
    #1;
    check("rst_busy", busy_o, 32'h0);
    check("rst_stall", {29'd0, pc_stall_o, ifid_stall_o, ctrl_mux_o}, 32'h0);
    check("rst_stall_cnt", {16'd0, stall_cnt_o}, 32'h0);
    model_reset();
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    step(1, st, bz);
    check("post_reset_no_stall", {31'd0, st}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
